// File: rtl/fetch_unit_pkg.sv
// Types and constants shared by the instruction fetch stage.
package fetch_unit_pkg;

  // Encodings match the FETCH_* macros in parameters.sv.
  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_WAIT    = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_e;

  localparam int unsigned RESET_VECTOR = 0;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched {pc, instruction} entries.
// Flush wins over push; a push and a pop on a full buffer are both accepted.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/parameters.sv
// Shared fetch-stage encodings for code that still works with text macros.
// The typed equivalents live in fetch_unit_pkg.
`ifndef FETCH_PARAMETERS_SV
`define FETCH_PARAMETERS_SV

`define FETCH_IDLE    2'd0
`define FETCH_WAIT    2'd1
`define FETCH_DISCARD 2'd2
`define RESET_VECTOR  0

`endif

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests program memory over req/ack,
// buffers returned bytes and handles jump redirects and halt.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter int          DATA_W   = 8,
  parameter int          DEPTH    = 2,
  parameter int unsigned RESET_PC = RESET_VECTOR
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_target,
  input  logic              halt
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic [ENT_W-1:0]  hold_q, hold_d;

  logic              buf_push, buf_pop, buf_flush, buf_full, buf_empty;
  logic [CNT_W-1:0]  buf_count, cnt_after;
  logic [ENT_W-1:0]  buf_rdata;
  logic              issue_ok;

  assign buf_pop   = !buf_empty && inst_ready;
  assign buf_flush = redir_valid;
  assign buf_push  = (state_q == FETCH_WAIT) && mem_ack && !redir_valid;

  // A new request reserves the slot its response will land in, so only one
  // outstanding request can never overflow the buffer.
  assign cnt_after = buf_count + CNT_W'(buf_push) - CNT_W'(buf_pop);
  assign issue_ok  = (cnt_after < CNT_W'(DEPTH)) && !(buf_full && !buf_pop)
                     && !halt && !redir_valid;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      FETCH_IDLE: begin
        if (redir_valid) begin
          pc_d = redir_target;
        end else if (issue_ok) begin
          state_d    = FETCH_WAIT;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
        end
      end
      FETCH_WAIT: begin
        if (redir_valid) begin
          pc_d = redir_target;
          if (mem_ack) begin
            state_d   = FETCH_IDLE;
            mem_req_d = 1'b0;
          end else begin
            // Request stays on the bus unchanged; its data is dropped later.
            state_d = FETCH_DISCARD;
          end
        end else if (mem_ack) begin
          pc_d = pc_q + ADDR_W'(1);
          if (issue_ok) begin
            mem_addr_d = pc_q + ADDR_W'(1);
          end else begin
            state_d   = FETCH_IDLE;
            mem_req_d = 1'b0;
          end
        end
      end
      FETCH_DISCARD: begin
        if (redir_valid) pc_d = redir_target;
        if (mem_ack) begin
          state_d   = FETCH_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = FETCH_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Remember the last head so inst/inst_pc hold once the buffer runs empty.
  always_comb begin
    hold_d = buf_empty ? hold_q : buf_rdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FETCH_IDLE;
      pc_q       <= ADDR_W'(RESET_PC);
      mem_req_q  <= 1'b0;
      mem_addr_q <= ADDR_W'(RESET_PC);
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      hold_q     <= hold_d;
    end
  end

  fetch_buffer #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (reset),
    .push  (buf_push),
    .pop   (buf_pop),
    .flush (buf_flush),
    .wdata ({pc_q, mem_rdata}),
    .rdata (buf_rdata),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  assign mem_req             = mem_req_q;
  assign mem_addr            = mem_addr_q;
  assign inst_valid          = !buf_empty;
  assign {inst_pc, inst}     = buf_empty ? hold_q : buf_rdata;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model plus scoreboard of fetched
// addresses, a redirect vector table and hand-written halt/reset sequences.
module tb_fetch_unit;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_target;
  logic              halt;
  logic              mdl_ack, tb_ack;

  always #5 clk = ~clk;
  assign mem_ack = mdl_ack | tb_ack;

  fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .RESET_PC (0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .halt         (halt)
  );

  int checks = 0;
  int errors = 0;

  // Values applied to the DUT at the next falling edge.
  logic              s_reset, s_ready, s_halt, s_redir;
  logic [ADDR_W-1:0] s_target;

  // Memory model and scoreboard state.
  int                ack_delay;
  int                wcnt;
  logic              busy;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] exp_pc;
  logic              drop_pend;
  logic              pushed_prev;
  logic [ADDR_W-1:0] exp_q [$];
  logic [ADDR_W-1:0] seen [$];
  int                npops, nkept;

  typedef struct {
    logic [ADDR_W-1:0] pre;
    logic [ADDR_W-1:0] tgt;
    int                delay;
    int                mode;   // 0: redirect while waiting, 1: redirect with ack, 2: no redirect
    logic [ADDR_W-1:0] exp_first;
    logic [ADDR_W-1:0] exp_second;
  } vec_t;

  vec_t vecs [4];

  function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
    return {a[3:0], a[7:4]} ^ 8'h3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
  endtask

  // One clock: drive inputs and memory response at negedge, score at negedge+1.
  task automatic step();
    logic [ADDR_W-1:0] e;
    @(negedge clk);
    reset        = s_reset;
    inst_ready   = s_ready;
    halt         = s_halt;
    redir_valid  = s_redir;
    redir_target = s_target;
    s_redir      = 1'b0;
    mdl_ack      = 1'b0;
    if (s_reset && mem_req) begin
      if (!busy) begin
        busy     = 1'b1;
        wcnt     = 0;
        req_addr = mem_addr;
      end else begin
        check("req_addr_stable", mem_addr, req_addr);
      end
      if (wcnt >= ack_delay) begin
        mdl_ack   = 1'b1;
        mem_rdata = mem_fn(mem_addr);
        busy      = 1'b0;
      end else begin
        wcnt++;
      end
    end else begin
      busy = 1'b0;
    end
    #1;
    if (!reset) begin
      exp_q.delete();
      drop_pend   = 1'b0;
      exp_pc      = '0;
      busy        = 1'b0;
      pushed_prev = 1'b0;
    end else begin
      check("valid_vs_model", inst_valid, exp_q.size() != 0);
      if (pushed_prev) check("ack_to_valid_latency", inst_valid, 1);
      pushed_prev = 1'b0;
      if (inst_valid && inst_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("inst_pc", inst_pc, e);
        check("inst", inst, mem_fn(e));
        seen.push_back(inst_pc);
        npops++;
      end
      if (mem_ack && mem_req) begin
        if (redir_valid || drop_pend) begin
          drop_pend = 1'b0;
        end else begin
          check("ack_addr", mem_addr, exp_pc);
          exp_q.push_back(exp_pc);
          exp_pc      = exp_pc + 1'b1;
          nkept++;
          pushed_prev = 1'b1;
        end
      end
      if (redir_valid) begin
        exp_q.delete();
        exp_pc      = redir_target;
        pushed_prev = 1'b0;
        if (mem_req && !mem_ack) drop_pend = 1'b1;
      end
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!mem_req && n < 30) begin
      step();
      n++;
    end
    check(name, mem_req, 1);
  endtask

  task automatic drain();
    int n = 0;
    s_halt  = 1'b1;
    s_ready = 1'b1;
    step();
    while ((mem_req || inst_valid) && n < 40) begin
      step();
      n++;
    end
    check("drain_done", mem_req || inst_valid, 0);
    check("drain_model_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_reset = 1'b0; s_ready = 1'b0; s_halt = 1'b0; s_redir = 1'b0; s_target = '0;
    reset = 1'b0; inst_ready = 1'b0; halt = 1'b0; redir_valid = 1'b0; redir_target = '0;
    mdl_ack = 1'b0; tb_ack = 1'b0; mem_rdata = '0;
    ack_delay = 0; wcnt = 0; busy = 1'b0; req_addr = '0; exp_pc = '0;
    drop_pend = 1'b0; pushed_prev = 1'b0; npops = 0; nkept = 0;

    vecs[0] = '{8'h05, 8'h40, 3, 0, 8'h40, 8'h41};
    vecs[1] = '{8'h10, 8'h20, 1, 1, 8'h20, 8'h21};
    vecs[2] = '{8'hFF, 8'h00, 0, 2, 8'hFF, 8'h00};
    vecs[3] = '{8'hFE, 8'hFF, 2, 0, 8'hFF, 8'h00};

    step();
    step();
    check_reset_outputs();

    // Streaming with a zero-wait memory: one instruction per cycle.
    s_reset = 1'b1; s_ready = 1'b1; ack_delay = 0;
    repeat (3) step();
    npops = 0;
    repeat (8) step();
    check("throughput_pops", npops, 8);
    drain();

    // Consumer stalled: exactly DEPTH responses are accepted.
    s_halt = 1'b0; s_reset = 1'b0; s_ready = 1'b0;
    step();
    s_reset = 1'b1; nkept = 0;
    repeat (8) step();
    check("stall_kept", nkept, 2);
    check("stall_mem_req", mem_req, 0);
    check("stall_valid", inst_valid, 1);
    check("stall_inst_pc", inst_pc, 0);
    check("stall_inst", inst, mem_fn(8'h00));
    s_ready = 1'b1;
    wait_req("resume_req");
    check("resume_addr", mem_addr, 2);
    repeat (4) step();
    drain();

    // Redirect / wrap vectors.
    for (int i = 0; i < 4; i++) begin
      int n;
      ack_delay = vecs[i].delay;
      s_ready   = 1'b1;
      s_halt    = 1'b1;
      s_target  = vecs[i].pre;
      s_redir   = 1'b1;
      step();
      s_halt = 1'b0;
      seen.delete();
      if (vecs[i].mode != 2) begin
        wait_req("vec_req");
        check("vec_req_addr", mem_addr, vecs[i].pre);
        if (vecs[i].mode == 1) repeat (vecs[i].delay - 1) step();
        s_target = vecs[i].tgt;
        s_redir  = 1'b1;
        step();
        step();
        if (vecs[i].mode == 0) begin
          check("vec_held_req", mem_req, 1);
          check("vec_held_addr", mem_addr, vecs[i].pre);
        end else begin
          check("vec_flush_valid", inst_valid, 0);
        end
      end
      n = 0;
      while (seen.size() < 2 && n < 40) begin
        step();
        n++;
      end
      check("vec_pops", seen.size() >= 2, 1);
      if (seen.size() >= 2) begin
        check("vec_first_pc", seen[0], vecs[i].exp_first);
        check("vec_second_pc", seen[1], vecs[i].exp_second);
      end
      drain();
    end

    // Halt during an outstanding request, then reset while halted.
    ack_delay = 3; s_ready = 1'b0; s_halt = 1'b1;
    s_target = 8'h30; s_redir = 1'b1;
    step();
    s_halt = 1'b0;
    wait_req("halt_req");
    s_halt = 1'b1;
    nkept = 0;
    for (int n = 0; n < 20 && nkept == 0; n++) step();
    check("halt_ack_buffered", nkept, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      check("halt_no_req", mem_req, 0);
    end
    check("halt_valid", inst_valid, 1);
    check("halt_inst_pc", inst_pc, 8'h30);
    check("halt_inst", inst, mem_fn(8'h30));
    s_reset = 1'b0;
    step();
    check_reset_outputs();
    s_reset = 1'b1;
    step();
    tb_ack = 1'b1;
    mem_rdata = 8'hEE;
    step();
    tb_ack = 1'b0;
    step();
    check("stray_ack_valid", inst_valid, 0);
    check("stray_ack_req", mem_req, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
